// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer.
// Holds the FSM state encoding, the note-table entry layout and the
// end-of-sequence marker value.
package melody_pkg;

  localparam int unsigned FREQ_W = 11;
  localparam int unsigned DUR_W  = 8;

  // A duration of zero terminates the sequence.
  localparam logic [DUR_W-1:0] END_MARK = '0;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLoad = 2'd1;
  localparam state_t StPlay = 2'd2;
  localparam state_t StGap  = 2'd3;

  // One note-table entry: oscillator frequency code plus length in ticks.
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_t;

endpackage

// File: rtl/melody_sequencer_if.sv
// Host-side bus of the melody sequencer.
// master: host/user logic (table writes, start/stop/loop; observes status).
// slave:  melody_sequencer (consumes controls, drives oscillator controls
//         freq/osc_en/osc_reset_n and status busy/note_idx/done).
interface melody_sequencer_if #(
  parameter int unsigned DEPTH = 16
) ();
  import melody_pkg::*;

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              wr_en;
  logic [AddrW-1:0]  wr_addr;
  logic [FREQ_W-1:0] wr_freq;
  logic [DUR_W-1:0]  wr_dur;
  logic              start;
  logic              stop;
  logic              loop;

  logic [FREQ_W-1:0] freq;
  logic              osc_en;
  logic              osc_reset_n;
  logic              busy;
  logic [AddrW-1:0]  note_idx;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_freq, wr_dur, start, stop, loop,
    input  freq, osc_en, osc_reset_n, busy, note_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_freq, wr_dur, start, stop, loop,
    output freq, osc_en, osc_reset_n, busy, note_idx, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Tempo prescaler: counts 0..TICK_DIV-1 while run is high and flags the
// wrap cycle with tick. clear forces the count back to 0 (priority over run).
// Ports: clk, reset (async, active-high), clear, run -> tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned   CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a host-written note table and drives the
// sine_cos oscillator controls (freq, osc_en, osc_reset_n), pulsing the
// oscillator reset at the start of each note and inserting a silent gap.
// Ports: clk, reset (async, active-high), bus (slave side of
// melody_sequencer_if: table write port, start/stop/loop, oscillator
// controls and busy/note_idx/done status). All bus outputs are registered.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned GAP_TICKS = 2
) (
  input logic               clk,
  input logic               reset,
  melody_sequencer_if.slave bus
);

  localparam int unsigned      AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrW-1:0] LastIdx = AddrW'(DEPTH - 1);
  localparam logic [DUR_W-1:0] GapCnt  = DUR_W'(GAP_TICKS);

  if (GAP_TICKS > 255) begin : gen_gap_too_big
    $error("GAP_TICKS does not fit the 8-bit tick counter");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_bad
    $error("DEPTH must be a power of two");
  end

  state_t            state_q, state_d;
  logic [AddrW-1:0]  idx_q, idx_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              en_q, en_d;
  logic              rstn_q, rstn_d;
  logic              done_q, done_d;
  logic [DUR_W-1:0]  ticks_q, ticks_d;

  note_t mem [DEPTH];
  note_t rd_q;

  logic tick, pre_run;
  logic advance, end_seq;

  assign pre_run = (state_q == StPlay) || (state_q == StGap);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (!pre_run),
    .run   (pre_run),
    .tick  (tick)
  );

  // Read address is the next-state index so the entry is ready during LOAD;
  // a write on the same edge returns the old data.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= {bus.wr_freq, bus.wr_dur};
    end
    rd_q <= mem[idx_d];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    freq_d  = freq_q;
    en_d    = en_q;
    rstn_d  = 1'b1;
    done_d  = 1'b0;
    ticks_d = ticks_q;
    advance = 1'b0;
    end_seq = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (rd_q.dur == END_MARK) begin
          end_seq = 1'b1;
        end else begin
          freq_d  = rd_q.freq;
          en_d    = (rd_q.freq != '0);
          rstn_d  = 1'b0;
          ticks_d = rd_q.dur;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick) begin
          ticks_d = ticks_q - 1'b1;
          if (ticks_q == 8'd1) begin
            en_d = 1'b0;
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              ticks_d = GapCnt;
              state_d = StGap;
            end
          end
        end
      end
      default: begin // StGap
        if (tick) begin
          ticks_d = ticks_q - 1'b1;
          if (ticks_q == 8'd1) begin
            advance = 1'b1;
          end
        end
      end
    endcase

    if (advance) begin
      if (idx_q == LastIdx) begin
        end_seq = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StLoad;
      end
    end

    if (end_seq) begin
      idx_d = '0;
      if (bus.loop) begin
        state_d = StLoad;
      end else begin
        state_d = StIdle;
        freq_d  = '0;
        en_d    = 1'b0;
        ticks_d = '0;
        done_d  = 1'b1;
      end
    end

    // Abort wins over everything, including a pending oscillator reset.
    if (bus.stop && state_q != StIdle) begin
      state_d = StIdle;
      idx_d   = '0;
      freq_d  = '0;
      en_d    = 1'b0;
      rstn_d  = 1'b1;
      done_d  = 1'b0;
      ticks_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      freq_q  <= '0;
      en_q    <= 1'b0;
      rstn_q  <= 1'b1;
      done_q  <= 1'b0;
      ticks_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      ticks_q <= ticks_d;
    end
  end

  assign bus.freq        = freq_q;
  assign bus.osc_en      = en_q;
  assign bus.osc_reset_n = rstn_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.note_idx    = idx_q;
  assign bus.done        = done_q;

endmodule
